// File: rtl/multdiv_stall_controller_if.sv
// ============================================================================
// Module   : multdiv_stall_controller_if
// Function : Pipeline-side and multdiv-side signal bundle for the stall controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface multdiv_stall_controller_if;
   logic [4:0]  op_X;
   logic [4:0]  ALU_X;
   logic        haz_PC_en;
   logic        haz_FD_en;
   logic [31:0] md_result;
   logic        md_resultRDY;
   logic        md_exception;

   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic        PC_en;
   logic        FD_en;
   logic        DX_en;
   logic        XM_en;
   logic        MW_en;
   logic        xm_bubble;
   logic        xm_sel_md;
   logic [31:0] md_held;
   logic        exc_valid;
   logic [31:0] exc_code;
   logic        busy;

   // Pipeline / multdiv environment side
   modport master (
      output op_X, ALU_X, haz_PC_en, haz_FD_en, md_result, md_resultRDY, md_exception,
      input  ctrl_MULT, ctrl_DIV, PC_en, FD_en, DX_en, XM_en, MW_en,
      input  xm_bubble, xm_sel_md, md_held, exc_valid, exc_code, busy
   );

   // Stall controller side
   modport slave (
      input  op_X, ALU_X, haz_PC_en, haz_FD_en, md_result, md_resultRDY, md_exception,
      output ctrl_MULT, ctrl_DIV, PC_en, FD_en, DX_en, XM_en, MW_en,
      output xm_bubble, xm_sel_md, md_held, exc_valid, exc_code, busy
   );
endinterface

`default_nettype wire

// File: rtl/multdiv_stall_controller.sv
// ============================================================================
// Module   : multdiv_stall_controller
// Function : Starts the multdiv unit from X, stalls PC/FD/DX and hands the result to XM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multdiv_stall_controller #(
   parameter int TIMEOUT = 40,
   parameter int CNT_W   = 6
) (
   input  wire                           clock,
   input  wire                           reset,
   multdiv_stall_controller_if.slave     bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [4:0]       ALU_MUL  = 5'b00110;
   localparam logic [4:0]       ALU_DIV  = 5'b00111;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        held_q, held_d;
   logic               kind_div_q, kind_div_d;
   logic               exc_q, exc_d;

   logic               is_mul;
   logic               is_div;

   assign is_mul = (bus.op_X == 5'd0) && (bus.ALU_X == ALU_MUL);
   assign is_div = (bus.op_X == 5'd0) && (bus.ALU_X == ALU_DIV);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         held_q     <= '0;
         kind_div_q <= 1'b0;
         exc_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         held_q     <= held_d;
         kind_div_q <= kind_div_d;
         exc_q      <= exc_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      held_d        = held_q;
      kind_div_d    = kind_div_q;
      exc_d         = exc_q;

      bus.ctrl_MULT = 1'b0;
      bus.ctrl_DIV  = 1'b0;
      bus.PC_en     = bus.haz_PC_en;
      bus.FD_en     = bus.haz_FD_en;
      bus.DX_en     = 1'b1;
      bus.XM_en     = 1'b1;
      bus.MW_en     = 1'b1;
      bus.xm_bubble = 1'b0;
      bus.xm_sel_md = 1'b0;
      bus.exc_valid = 1'b0;
      bus.exc_code  = 32'd0;

      // While reset is held the pipeline runs freely and no op may start.
      if (!reset) begin
         bus.PC_en = 1'b1;
         bus.FD_en = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (is_mul || is_div) begin
                  bus.ctrl_MULT = is_mul;
                  bus.ctrl_DIV  = is_div;
                  bus.PC_en     = 1'b0;
                  bus.FD_en     = 1'b0;
                  bus.DX_en     = 1'b0;
                  bus.xm_bubble = 1'b1;
                  kind_div_d    = is_div;
                  cnt_d         = '0;
                  state_d       = BUSY;
               end
            end
            BUSY: begin
               bus.PC_en     = 1'b0;
               bus.FD_en     = 1'b0;
               bus.DX_en     = 1'b0;
               bus.xm_bubble = 1'b1;
               cnt_d         = cnt_q + 1'b1;
               // A result arriving on the timeout cycle takes priority over the abort.
               if (bus.md_resultRDY) begin
                  held_d  = bus.md_result;
                  exc_d   = bus.md_exception;
                  state_d = DONE;
               end else if (cnt_q == CNT_LAST) begin
                  held_d  = 32'd0;
                  exc_d   = 1'b1;
                  state_d = DONE;
               end
            end
            DONE: begin
               bus.xm_sel_md = 1'b1;
               bus.exc_valid = exc_q;
               if (exc_q) begin
                  bus.exc_code = kind_div_q ? 32'd5 : 32'd4;
               end
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign bus.md_held = held_q;
   assign bus.busy    = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_multdiv_stall_controller.sv
// ============================================================================
// Module   : tb_multdiv_stall_controller
// Function : Directed plus randomized checks of the multdiv stall controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multdiv_stall_controller;

   localparam int TIMEOUT = 40;
   localparam int CNT_W   = 6;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   multdiv_stall_controller_if bus ();

   multdiv_stall_controller #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare every output against the expected cycle behaviour.
   task automatic expect_out(input string tag, input bit mult, input bit div,
                             input bit pc, input bit fd, input bit dx, input bit bub,
                             input bit sel, input bit ev, input logic [31:0] code,
                             input bit bsy, input bit chk_held, input logic [31:0] held);
      chk({tag, ".ctrl_MULT"}, 32'(bus.ctrl_MULT), 32'(mult));
      chk({tag, ".ctrl_DIV"},  32'(bus.ctrl_DIV),  32'(div));
      chk({tag, ".PC_en"},     32'(bus.PC_en),     32'(pc));
      chk({tag, ".FD_en"},     32'(bus.FD_en),     32'(fd));
      chk({tag, ".DX_en"},     32'(bus.DX_en),     32'(dx));
      chk({tag, ".XM_en"},     32'(bus.XM_en),     32'd1);
      chk({tag, ".MW_en"},     32'(bus.MW_en),     32'd1);
      chk({tag, ".xm_bubble"}, 32'(bus.xm_bubble), 32'(bub));
      chk({tag, ".xm_sel_md"}, 32'(bus.xm_sel_md), 32'(sel));
      chk({tag, ".exc_valid"}, 32'(bus.exc_valid), 32'(ev));
      chk({tag, ".exc_code"},  bus.exc_code,       code);
      chk({tag, ".busy"},      32'(bus.busy),      32'(bsy));
      if (chk_held) chk({tag, ".md_held"}, bus.md_held, held);
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic set_nonmd(input logic [4:0] op, input logic [4:0] alu);
      bus.op_X  = op;
      bus.ALU_X = alu;
      if (op == 5'd0 && (alu == 5'd6 || alu == 5'd7)) bus.ALU_X = 5'd0;
   endtask

   // One cycle with a non-multdiv instruction in X: enables pass through.
   task automatic idle_cycle(input logic [4:0] op, input logic [4:0] alu,
                             input bit hpc, input bit hfd, input bit rdy_noise);
      set_nonmd(op, alu);
      bus.haz_PC_en    = hpc;
      bus.haz_FD_en    = hfd;
      bus.md_resultRDY = rdy_noise;
      bus.md_result    = $urandom;
      bus.md_exception = 1'($urandom);
      @(negedge clock);
      expect_out("idle", 0, 0, hpc, hfd, 1, 0, 0, 0, 32'd0, 0, 0, 32'd0);
      next_cycle();
   endtask

   // A whole mul/div transaction. rdy_at in 1..TIMEOUT pulses RDY on that BUSY
   // cycle; any other value means the unit never answers and the op times out.
   task automatic run_op(input bit is_div, input int rdy_at, input logic [31:0] result,
                         input bit exc_in);
      bit          answered;
      int          n_busy;
      logic [31:0] exp_held;
      bit          exp_exc;
      logic [31:0] exp_code;
      bit          hpc;
      bit          hfd;

      answered = (rdy_at >= 1) && (rdy_at <= TIMEOUT);
      n_busy   = answered ? rdy_at : TIMEOUT;
      exp_held = answered ? result : 32'd0;
      exp_exc  = answered ? exc_in : 1'b1;
      exp_code = exp_exc ? (is_div ? 32'd5 : 32'd4) : 32'd0;

      bus.op_X         = 5'd0;
      bus.ALU_X        = is_div ? 5'b00111 : 5'b00110;
      bus.haz_PC_en    = 1'($urandom);
      bus.haz_FD_en    = 1'($urandom);
      bus.md_resultRDY = 1'($urandom);
      bus.md_result    = $urandom;
      bus.md_exception = 1'($urandom);
      @(negedge clock);
      expect_out("start", !is_div, is_div, 0, 0, 0, 1, 0, 0, 32'd0, 0, 0, 32'd0);
      next_cycle();

      for (int i = 1; i <= n_busy; i++) begin
         bus.haz_PC_en    = 1'($urandom);
         bus.haz_FD_en    = 1'($urandom);
         bus.md_resultRDY = (i == rdy_at);
         bus.md_result    = (i == rdy_at) ? result : $urandom;
         bus.md_exception = (i == rdy_at) ? exc_in : 1'($urandom);
         @(negedge clock);
         expect_out("busy", 0, 0, 0, 0, 0, 1, 0, 0, 32'd0, 1, 0, 32'd0);
         next_cycle();
      end

      hpc              = 1'($urandom);
      hfd              = 1'($urandom);
      bus.haz_PC_en    = hpc;
      bus.haz_FD_en    = hfd;
      bus.md_resultRDY = 1'($urandom);
      bus.md_result    = $urandom;
      bus.md_exception = 1'($urandom);
      @(negedge clock);
      expect_out("done", 0, 0, hpc, hfd, 1, 0, 1, exp_exc, exp_code, 1, 1, exp_held);
      next_cycle();
   endtask

   initial begin
      bus.op_X         = 5'd0;
      bus.ALU_X        = 5'b00110;
      bus.haz_PC_en    = 1'b0;
      bus.haz_FD_en    = 1'b0;
      bus.md_result    = 32'd0;
      bus.md_resultRDY = 1'b0;
      bus.md_exception = 1'b0;

      // Reset held with a mul in X and hazard stall requested.
      repeat (2) @(posedge clock);
      @(negedge clock);
      expect_out("rst", 0, 0, 1, 1, 1, 0, 0, 0, 32'd0, 0, 1, 32'd0);
      next_cycle();
      bus.ALU_X = 5'd0;
      reset = 1'b1;
      next_cycle();

      // add with hazard stall; decode boundary: ALU field 6 with nonzero opcode.
      idle_cycle(5'd0, 5'd0, 0, 0, 0);
      idle_cycle(5'd1, 5'd6, 1, 1, 1);
      idle_cycle(5'd0, 5'd8, 1, 0, 0);

      run_op(0, 32, 32'd12, 0);              // mul 3*4
      idle_cycle(5'd0, 5'd0, 1, 1, 0);
      run_op(1, 32, 32'hDEAD_BEEF, 1);       // div 7/0
      idle_cycle(5'd0, 5'd0, 1, 1, 0);
      run_op(0, 0, 32'd99, 0);               // mul timeout
      idle_cycle(5'd0, 5'd0, 1, 1, 0);
      run_op(1, TIMEOUT, 32'd77, 0);         // RDY on the timeout cycle wins
      run_op(0, 5, 32'd30, 0);               // back-to-back mul then div
      run_op(1, 7, 32'd2, 0);
      run_op(0, 1, 32'h1234_5678, 0);        // single BUSY cycle
      idle_cycle(5'd3, 5'd0, 1, 1, 1);

      // Asynchronous reset mid-operation at BUSY cycle 10.
      bus.op_X      = 5'd0;
      bus.ALU_X     = 5'b00110;
      bus.haz_PC_en = 1'b0;
      bus.haz_FD_en = 1'b0;
      bus.md_resultRDY = 1'b0;
      next_cycle();
      repeat (9) next_cycle();
      @(negedge clock);
      chk("rst_mid.busy_before", 32'(bus.busy), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      expect_out("rst_mid", 0, 0, 1, 1, 1, 0, 0, 0, 32'd0, 0, 1, 32'd0);
      next_cycle();
      bus.op_X  = 5'd0;
      bus.ALU_X = 5'd0;
      reset = 1'b1;
      idle_cycle(5'd0, 5'd0, 0, 0, 1);       // late RDY ignored
      idle_cycle(5'd0, 5'd0, 1, 1, 0);

      // Randomized transactions interleaved with idle traffic.
      for (int n = 0; n < 30; n++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            idle_cycle(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         end
         run_op(1'($urandom), $urandom_range(0, TIMEOUT + 5), $urandom, 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/multdiv_stall_controller.md
Name: multdiv_stall_controller

Overview:
Sequences the multi-cycle multiply/divide unit for the 5-stage pipeline. It detects mul/div in the X stage and issues a one-cycle start pulse to the unit. While the unit runs it freezes PC/FD/DX and feeds bubbles into XM. When the result is ready it hands the result and any exception to XM. It replaces the constant-1 DX/XM/MW enables and gates the hazard-stall PC/FD enables.

Parameters:
TIMEOUT, 40, cycles in BUSY before the operation is aborted as a fault.
CNT_W, 6, width of the busy-cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clock  in  1  master clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
op_X  in  5  opcode of instruction in X
ALU_X  in  5  ALU op field of instruction in X
haz_PC_en  in  1  PC enable from the load-use hazard stall logic
haz_FD_en  in  1  FD enable from the load-use hazard stall logic
md_result  in  32  multdiv unit result
md_resultRDY  in  1  multdiv result valid (single-cycle pulse)
md_exception  in  1  multdiv overflow / divide-by-zero, valid with md_resultRDY
ctrl_MULT  out  1  start-multiply pulse
ctrl_DIV  out  1  start-divide pulse
PC_en, FD_en, DX_en, XM_en, MW_en  out  1 each  pipeline register enables
xm_bubble  out  1  1 = XM latches a NOP (instr 0) instead of X
xm_sel_md  out  1  1 = XM output operand takes md_held instead of the ALU output
md_held  out  32  captured result
exc_valid  out  1  rstatus (r30) write request, valid with xm_sel_md
exc_code  out  32  rstatus value: 4 mul, 5 div, else 0
busy  out  1  state != IDLE

Behaviour:
- Decode: is_mul = (op_X==0 && ALU_X==00110); is_div = (op_X==0 && ALU_X==00111).
- States: IDLE, BUSY, DONE. Registers: state, cnt[CNT_W], md_held, kind (mul/div), exc_flag.
- IDLE, no md op:
  - PC_en = haz_PC_en, FD_en = haz_FD_en, DX_en = 1.
  - xm_bubble = 0, xm_sel_md = 0, no start pulse.
- IDLE, is_mul or is_div:
  - ctrl_MULT or ctrl_DIV = 1 for this cycle only.
  - PC_en = FD_en = DX_en = 0, xm_bubble = 1.
  - kind <= op, cnt <= 0, next state BUSY.
  - md_resultRDY in this cycle is ignored.
- BUSY:
  - PC_en = FD_en = DX_en = 0, xm_bubble = 1, start pulses = 0, cnt <= cnt + 1.
  - md_resultRDY = 1: md_held <= md_result, exc_flag <= md_exception, next state DONE.
  - Else if cnt == TIMEOUT-1: md_held <= 0, exc_flag <= 1, next state DONE.
  - md_resultRDY and timeout in the same cycle: the result wins.
- DONE (exactly one cycle):
  - Enables follow the IDLE/no-op rule, xm_bubble = 0, xm_sel_md = 1.
  - exc_valid = exc_flag; exc_code = 4 (mul) or 5 (div) when exc_flag, else 0.
  - The instruction leaves X this cycle; next state IDLE.
  - md_resultRDY seen in DONE is ignored.
- XM_en = MW_en = 1 at all times; downstream drains during the stall.
- Latency: start pulse, then N BUSY cycles until RDY, then 1 DONE cycle. The instruction occupies X for N+2 cycles.
- Back-to-back mul/div: the second is detected in the IDLE cycle after DONE and starts normally. No re-trigger of the first, because DX_en = 1 in DONE.
- Operand capture is the unit's job, latched on the start pulse from the bypassed ALU inputs.
- Reset asserted (reset == 0), asynchronous and taking effect mid-operation:
  - Registered state: state = IDLE, cnt = 0, md_held = 0, exc_flag = 0, kind = mul.
  - Outputs while held: start pulses 0, PC/FD/DX/XM/MW_en = 1, xm_bubble = 0, xm_sel_md = 0, exc_valid = 0, exc_code = 0, busy = 0.
  - The in-flight op is discarded; a late md_resultRDY after reset release is ignored in IDLE.

Test Plan:
- mul 3*4 in X, RDY after 32 BUSY cycles with md_result=12 -> ctrl_MULT high 1 cycle; PC/FD/DX_en=0 for 33 cycles; DONE: xm_sel_md=1, md_held=12, exc_valid=0.
- div 7/0, RDY with md_exception=1 after 32 cycles -> DONE: exc_valid=1, exc_code=5, xm_sel_md=1.
- mul, RDY never asserted, TIMEOUT=40 -> DONE after exactly 40 BUSY cycles: md_held=0, exc_code=4, exc_valid=1.
- mul immediately followed by div -> two start pulses separated by N+2 cycles; second DONE returns div result; no double ctrl_MULT.
- reset pulled low at BUSY cycle 10, released, RDY pulses next cycle -> state IDLE, all enables 1, busy=0, RDY ignored, no xm_sel_md.
- add in X with haz_PC_en=haz_FD_en=0 -> PC_en=FD_en=0, DX_en=1, xm_bubble=0, no start pulse.
